student_status_reader: RTL and testbench
========================================

Name: student_status_reader

Overview:
SoC-side consumer of the four 32-bit status words driven out of a student analog area. Each word is crossed from the student domain through a synchronizer and a stability filter. The block keeps per-channel snapshots and change flags, and exposes them to the system bus through an APB3 register slave. A level interrupt fires on filtered status changes.

Parameters:
SYNC_STAGES, 2, flip-flop stages in each status-bit synchronizer (min 2)
FILTER_LEN, 4, consecutive identical synchronized samples required before a value is accepted (min 1, max 255)
APB_AW, 5, APB address width (byte address)

Ports:
clk_in  input  1  block clock
reset_int  input  1  asynchronous active-low reset
status_0_in  input  32  student status word 0, asynchronous to clk_in
status_1_in  input  32  student status word 1
status_2_in  input  32  student status word 2
status_3_in  input  32  student status word 3
PSEL  input  1  APB select
PENABLE  input  1  APB enable
PWRITE  input  1  APB write
PADDR  input  APB_AW  APB byte address
PWDATA  input  32  APB write data
PRDATA  output  32  APB read data
PREADY  output  1  APB ready, tied 1
PSLVERR  output  1  APB error
irq  output  1  level interrupt, registered

Behaviour:
- Reset: asynchronous on reset_int low. All of the following are cleared to 0: sync flops, candidates, filter counters, filtered values, snapshots, CHANGE, IRQ_EN, CTRL, SNAP_CNT, PRDATA, PSLVERR, irq. Reset asserted mid-transfer aborts the transfer; no partial register update.
- Synchronizer: each input bit passes SYNC_STAGES flops, giving sync_i.
- Filter, per channel, state {candidate, cnt, filtered}:
  - If sync_i != candidate: candidate<=sync_i, cnt<=0.
  - Else if cnt < FILTER_LEN-1: cnt++.
  - Else if candidate != filtered: filtered<=candidate and pulse chg_i for one cycle.
  - A word that toggles faster than FILTER_LEN cycles is never accepted.
- Latency: an input held stable from edge t is in filtered_i at edge t+SYNC_STAGES+FILTER_LEN, worst case +1 for cnt alignment.
- CHANGE[3:0] (0x10, W1C):
  - Bit i sets on chg_i.
  - Writing 1 clears a bit. If chg_i and a W1C of bit i land in the same cycle, set wins.
- IRQ_EN[3:0] (0x14, RW).
- irq <= |(CHANGE & IRQ_EN), registered, so irq follows the flags by 1 cycle.
- CTRL (0x18): bit1 AUTO (RW), bit0 SNAP (write-1 strobe, reads 0). Other bits RO 0.
  - AUTO=1: snap_i<=filtered_i on every cycle chg_i pulses.
  - AUTO=0 with a SNAP write: all four snap_i<=filtered_i atomically on the write's access cycle, and SNAP_CNT++.
  - SNAP writes with AUTO=1 still capture and count.
- SNAP_CNT[15:0] (0x1C, RO): 16-bit, wraps 0xFFFF->0x0000.
- STATUSn_SNAP (0x00, 0x04, 0x08, 0x0C, RO): snap_n.
- APB:
  - Zero wait states. The access phase is PSEL&PENABLE.
  - Writes take effect at the end of the access cycle.
  - PRDATA is valid during the access phase. A read concurrent with a snapshot update returns the pre-update value.
  - Writes to RO registers are ignored with no error.
  - An address >= 0x20, or PADDR[1:0]!=0, gives PSLVERR=1 for that access only, PRDATA=0, and no state change.
- Bus ports are sampled only when PSEL=1. Status inputs are never used combinationally.

Test Plan:
- Reset values: assert reset_int mid-run -> all registers read 0, irq=0, PREADY=1.
- Filter and latency:
  - status_2_in=0xA5A5_0001 held 20 cycles -> filtered updates within SYNC_STAGES+FILTER_LEN+1=7 cycles; CHANGE=0x4.
  - With IRQ_EN=0x4, irq rises 1 cycle after the flag.
- Glitch rejection: status_1_in toggles 0x1<->0x0 every 2 cycles for 50 cycles -> CHANGE[1] stays 0, STATUS1_SNAP unchanged.
- Manual snapshot:
  - AUTO=0, change status_0_in to 0x1234_5678 and wait -> STATUS0_SNAP still 0.
  - Write CTRL=0x1 -> STATUS0_SNAP=0x1234_5678, SNAP_CNT=1, CTRL reads 0.
  - 65536 SNAP writes -> SNAP_CNT wraps to 1.
- W1C race: force chg_3 in the same cycle as W1C 0x8 -> CHANGE[3]=1; a later W1C 0x8 with no event -> 0, irq deasserts next cycle.
- Bus errors: read 0x24 -> PSLVERR=1, PRDATA=0; write 0x02 -> PSLVERR=1, no register changes; write 0x00 -> no error, STATUS0_SNAP unchanged.

Source files
------------

// File: rtl/student_status_reader.sv
// rtl/student_status_reader.sv - synchronized, filtered student status words behind an APB3 register slave
module student_status_reader #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int APB_AW      = 5
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic [31:0]       status_0_in,
    input  logic [31:0]       status_1_in,
    input  logic [31:0]       status_2_in,
    input  logic [31:0]       status_3_in,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              irq
);

    localparam logic [7:0] CNT_MAX = 8'(FILTER_LEN - 1);

    logic [31:0] status_in [4];
    logic [31:0] sync_ff   [4][SYNC_STAGES];
    logic [31:0] sync_val  [4];
    logic [31:0] cand      [4];
    logic [7:0]  cnt       [4];
    logic [31:0] filt      [4];
    logic [31:0] snap      [4];
    logic [3:0]  chg;
    logic [3:0]  change;
    logic [3:0]  irq_en;
    logic        auto_snap;
    logic [15:0] snap_cnt;

    logic [31:0] addr_ext;
    logic [2:0]  reg_idx;
    logic        addr_bad;
    logic        setup;
    logic        access;
    logic        wr_ok;
    logic        snap_strobe;
    logic [31:0] rd_mux;
    logic        unused_ok;

    assign status_in[0] = status_0_in;
    assign status_in[1] = status_1_in;
    assign status_in[2] = status_2_in;
    assign status_in[3] = status_3_in;

    assign PREADY      = 1'b1;
    assign addr_ext    = 32'(PADDR);
    assign reg_idx     = PADDR[4:2];
    assign addr_bad    = (addr_ext >= 32'h20) || (PADDR[1:0] != 2'b00);
    assign setup       = PSEL && !PENABLE;
    assign access      = PSEL && PENABLE;
    assign wr_ok       = access && PWRITE && !addr_bad;
    assign snap_strobe = wr_ok && (reg_idx == 3'd6) && PWDATA[0];
    assign unused_ok   = &{1'b0, PWDATA[31:4]};

    // Multi-flop synchronizer per status bit; the last stage is the only consumer-visible copy
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            for (int i = 0; i < 4; i++)
                for (int s = 0; s < SYNC_STAGES; s++)
                    sync_ff[i][s] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                sync_ff[i][0] <= status_in[i];
                for (int s = 1; s < SYNC_STAGES; s++)
                    sync_ff[i][s] <= sync_ff[i][s-1];
            end
        end
    end

    // Acceptance pulse: candidate has been stable long enough and differs from the accepted value
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            sync_val[i] = sync_ff[i][SYNC_STAGES-1];
            chg[i]      = (sync_val[i] == cand[i]) && !(cnt[i] < CNT_MAX) && (cand[i] != filt[i]);
        end
    end

    // Stability filter: restart the count whenever the synchronized word moves
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            for (int i = 0; i < 4; i++) begin
                cand[i] <= '0;
                cnt[i]  <= '0;
                filt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync_val[i] != cand[i]) begin
                    cand[i] <= sync_val[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] < CNT_MAX) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end else if (cand[i] != filt[i]) begin
                    filt[i] <= cand[i];
                end
            end
        end
    end

    // Register file updates; an acceptance in the same cycle as a W1C keeps the flag set
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            change    <= '0;
            irq_en    <= '0;
            auto_snap <= 1'b0;
            snap_cnt  <= '0;
            for (int i = 0; i < 4; i++)
                snap[i] <= '0;
        end else begin
            change <= (change & ~((wr_ok && reg_idx == 3'd4) ? PWDATA[3:0] : 4'h0)) | chg;
            if (wr_ok && reg_idx == 3'd5)
                irq_en <= PWDATA[3:0];
            if (wr_ok && reg_idx == 3'd6)
                auto_snap <= PWDATA[1];
            if (snap_strobe)
                snap_cnt <= snap_cnt + 16'd1;
            for (int i = 0; i < 4; i++) begin
                // cand already holds the value being accepted this cycle
                if (auto_snap && chg[i])
                    snap[i] <= cand[i];
                else if (snap_strobe)
                    snap[i] <= filt[i];
            end
        end
    end

    // Level interrupt, one cycle behind the flags
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int)
            irq <= 1'b0;
        else
            irq <= |(change & irq_en);
    end

    // Read mux over the register map
    always_comb begin
        rd_mux = '0;
        case (reg_idx)
            3'd0: rd_mux = snap[0];
            3'd1: rd_mux = snap[1];
            3'd2: rd_mux = snap[2];
            3'd3: rd_mux = snap[3];
            3'd4: rd_mux = {28'h0, change};
            3'd5: rd_mux = {28'h0, irq_en};
            3'd6: rd_mux = {30'h0, auto_snap, 1'b0};
            3'd7: rd_mux = {16'h0, snap_cnt};
            default: rd_mux = '0;
        endcase
    end

    // Read data and error are captured in the setup cycle so they are stable for the whole access phase
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end else if (setup) begin
            PRDATA  <= (addr_bad || PWRITE) ? 32'h0 : rd_mux;
            PSLVERR <= addr_bad;
        end else begin
            PRDATA  <= '0;
            PSLVERR <= 1'b0;
        end
    end

endmodule

// File: tb/tb_student_status_reader.sv
// tb/tb_student_status_reader.sv - directed table-driven bench for student_status_reader
module tb_student_status_reader;

    logic        clk_in;
    logic        reset_int;
    logic [31:0] status_0_in, status_1_in, status_2_in, status_3_in;
    logic        PSEL, PENABLE, PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR, irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic        chk_data;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t reset_vecs [8];
    vec_t err_vecs   [10];

    student_status_reader #(.SYNC_STAGES(2), .FILTER_LEN(4), .APB_AW(6)) dut (
        .clk_in      (clk_in),
        .reset_int   (reset_int),
        .status_0_in (status_0_in),
        .status_1_in (status_1_in),
        .status_2_in (status_2_in),
        .status_3_in (status_3_in),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR),
        .irq         (irq)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Called 1 time unit after an edge; returns 1 time unit after the access-ending edge
    task automatic apb_xfer(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        tick(1);
        PENABLE = 1'b1;
        rdata = PRDATA;
        err   = PSLVERR;
        tick(1);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_write(input logic [5:0] addr, input logic [31:0] wdata);
        logic [31:0] d;
        logic e;
        apb_xfer(1'b1, addr, wdata, d, e);
    endtask

    task automatic read_check(input string name, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic e;
        apb_xfer(1'b0, addr, 32'h0, d, e);
        check(name, d, exp);
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        logic [31:0] d;
        logic e;
        apb_xfer(v.wr, v.addr, v.wdata, d, e);
        check($sformatf("%s_err_%02h", tag, v.addr), {31'h0, e}, {31'h0, v.exp_err});
        if (v.chk_data)
            check($sformatf("%s_rdata_%02h", tag, v.addr), d, v.exp_rdata);
    endtask

    initial begin
        int n;

        for (int i = 0; i < 8; i++)
            reset_vecs[i] = '{1'b0, 6'(i * 4), 32'h0, 1'b1, 32'h0, 1'b0};

        err_vecs[0] = '{1'b0, 6'h24, 32'h0,        1'b1, 32'h0,        1'b1};
        err_vecs[1] = '{1'b1, 6'h02, 32'hFFFF_FFFF, 1'b0, 32'h0,       1'b1};
        err_vecs[2] = '{1'b1, 6'h15, 32'h0,        1'b0, 32'h0,        1'b1};
        err_vecs[3] = '{1'b0, 6'h14, 32'h0,        1'b1, 32'h8,        1'b0};
        err_vecs[4] = '{1'b1, 6'h00, 32'hFFFF_FFFF, 1'b0, 32'h0,       1'b0};
        err_vecs[5] = '{1'b0, 6'h00, 32'h0,        1'b1, 32'h1234_5678, 1'b0};
        err_vecs[6] = '{1'b1, 6'h1C, 32'h5,        1'b0, 32'h0,        1'b0};
        err_vecs[7] = '{1'b0, 6'h1C, 32'h0,        1'b1, 32'h1,        1'b0};
        err_vecs[8] = '{1'b0, 6'h18, 32'h0,        1'b1, 32'h0,        1'b0};
        err_vecs[9] = '{1'b0, 6'h22, 32'h0,        1'b1, 32'h0,        1'b1};

        reset_int = 1'b0;
        PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
        status_0_in = '0; status_1_in = '0; status_2_in = '0; status_3_in = '0;
        tick(3);
        reset_int = 1'b1;
        tick(1);

        // Populate state, then abort a write with a mid-transfer reset
        apb_write(6'h14, 32'hF);
        apb_write(6'h18, 32'h2);
        status_0_in = 32'hDEAD_BEEF;
        tick(15);
        check("pre_reset_irq", {31'h0, irq}, 32'h1);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 6'h14; PWDATA = 32'h0;
        tick(1);
        PENABLE = 1;
        #2;
        reset_int = 1'b0;
        status_0_in = '0;
        #1;
        check("reset_irq_async", {31'h0, irq}, 32'h0);
        tick(1);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        tick(2);
        reset_int = 1'b1;
        tick(1);
        check("reset_pready", {31'h0, PREADY}, 32'h1);
        for (int i = 0; i < 8; i++)
            apply_vec("reset", reset_vecs[i]);
        check("reset_irq", {31'h0, irq}, 32'h0);

        // Filter latency and interrupt timing on channel 2
        apb_write(6'h14, 32'h4);
        status_2_in = 32'hA5A5_0001;
        n = 0;
        while (!irq && n < 30) begin
            tick(1);
            n++;
        end
        check("latency_irq_cycles", 32'(n), 32'd8);
        tick(12);
        read_check("latency_change", 6'h10, 32'h4);
        read_check("latency_snap2_manual", 6'h08, 32'h0);
        apb_write(6'h10, 32'hF);
        apb_write(6'h14, 32'h0);

        // Glitch rejection on channel 1
        for (int i = 0; i < 25; i++) begin
            status_1_in = status_1_in ^ 32'h1;
            tick(2);
        end
        status_1_in = 32'h0;
        tick(10);
        read_check("glitch_change", 6'h10, 32'h0);
        read_check("glitch_snap1", 6'h04, 32'h0);

        // Manual snapshot
        status_0_in = 32'h1234_5678;
        tick(15);
        read_check("manual_snap0_before", 6'h00, 32'h0);
        apb_write(6'h18, 32'h1);
        read_check("manual_snap0_after", 6'h00, 32'h1234_5678);
        read_check("manual_snap2_after", 6'h08, 32'hA5A5_0001);
        read_check("manual_snap_cnt", 6'h1C, 32'h1);
        read_check("manual_ctrl", 6'h18, 32'h0);
        read_check("manual_change", 6'h10, 32'h1);

        // Automatic snapshot on channel 1
        apb_write(6'h18, 32'h2);
        status_1_in = 32'h77;
        tick(12);
        read_check("auto_snap1", 6'h04, 32'h77);
        read_check("auto_ctrl", 6'h18, 32'h2);
        read_check("auto_snap_cnt", 6'h1C, 32'h1);
        apb_write(6'h18, 32'h0);

        // W1C landing on the same edge as an acceptance on channel 3
        apb_write(6'h10, 32'hF);
        apb_write(6'h14, 32'h8);
        read_check("race_change_clear", 6'h10, 32'h0);
        status_3_in = 32'h0000_0008;
        tick(5);
        apb_write(6'h10, 32'h8);
        read_check("race_change_set_wins", 6'h10, 32'h8);
        check("race_irq_high", {31'h0, irq}, 32'h1);
        apb_write(6'h10, 32'h8);
        check("w1c_irq_lag", {31'h0, irq}, 32'h1);
        tick(1);
        check("w1c_irq_low", {31'h0, irq}, 32'h0);
        read_check("w1c_change", 6'h10, 32'h0);

        // Bus errors and read-only writes
        for (int i = 0; i < 10; i++)
            apply_vec("bus", err_vecs[i]);
        read_check("bus_irq_en_kept", 6'h14, 32'h8);

        // SNAP_CNT wrap: stream back-to-back access-phase strobes
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 6'h18; PWDATA = 32'h1;
        tick(1);
        PENABLE = 1;
        tick(65534);
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        read_check("wrap_ffff", 6'h1C, 32'hFFFF);
        apb_write(6'h18, 32'h1);
        read_check("wrap_zero", 6'h1C, 32'h0);
        apb_write(6'h18, 32'h1);
        read_check("wrap_one", 6'h1C, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
